seg_scan_driver: RTL and testbench

Time-multiplexed, parametrised seven-segment display driver for the board-level display path. It holds NDIG hex digits plus decimal points, and scans one digit per refresh slot through shared active-low segment lines and per-digit common enables. It adds tear-free frame loading, leading-zero suppression and anti-ghosting dead time. It replaces per-digit static hex decoders wherever pin count matters.

---
 rtl/seg_pkg.sv | 32 +++
 rtl/hex7seg.sv | 11 +
 rtl/seg_scan_driver.sv | 153 +++++++++++++++
 tb/tb_seg_scan_driver.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: blank pattern and the hex glyph table
// (gfedcba, bit0 = a, active-low).
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    seg = SEG_OFF;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational hex digit to active-low seven-segment decoder.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb seg_o = hex_to_seg(hex_i);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scanner with tear-free frame loading,
// leading-zero blanking and per-slot dead time.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NDIG           = 4,
  parameter int CLK_DIV        = 50000,
  parameter int DEAD_CYC       = 2,
  parameter bit COM_ACTIVE_LOW = 1'b1
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iEN,
  input  logic [4*NDIG-1:0] iVALUE,
  input  logic [NDIG-1:0]   iDP,
  input  logic              iLZ,
  input  logic              iLOAD,
  output logic [6:0]        oSEG,
  output logic              oDP,
  output logic [NDIG-1:0]   oCOM,
  output logic              oFRAME
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0]   PRE_DEAD = PW'(DEAD_CYC);
  localparam logic [IW-1:0]   IDX_LAST = IW'(NDIG - 1);
  localparam logic [NDIG-1:0] COM_OFF  = COM_ACTIVE_LOW ? {NDIG{1'b1}} : {NDIG{1'b0}};

  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [4*NDIG-1:0] stg_val_q, stg_val_d, disp_val_q, disp_val_d;
  logic [NDIG-1:0]   stg_dp_q, stg_dp_d, disp_dp_q, disp_dp_d;
  logic              stg_lz_q, stg_lz_d, disp_lz_q, disp_lz_d;
  logic              pend_q, pend_d, frame_pend_q, frame_pend_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d, frame_q, frame_d;
  logic [NDIG-1:0]   com_q, com_d;

  logic              slot_end, wrap, lit;
  logic [NDIG-1:0]   blank, com_on;
  logic [3:0]        cur_hex;
  logic              cur_dp, cur_blank;
  logic [6:0]        hex_seg;

  hex7seg u_dec (
    .hex_i (cur_hex),
    .seg_o (hex_seg)
  );

  // Blank digit i when it and everything to its left is zero; digit 0 always shows.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    blank    = '0;
    for (int i = NDIG - 1; i > 0; i--) begin
      zero_run = zero_run && (disp_val_q[4*i +: 4] == 4'h0);
      blank[i] = disp_lz_q && zero_run;
    end
  end

  always_comb begin
    cur_hex   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_q == IW'(i)) begin
        cur_hex   = disp_val_q[4*i +: 4];
        cur_dp    = disp_dp_q[i];
        cur_blank = blank[i];
      end
    end
  end

  always_comb begin
    slot_end = iEN && (presc_q == PRE_LAST);
    wrap     = slot_end && (idx_q == IDX_LAST);

    presc_d = presc_q;
    idx_d   = idx_q;
    if (iEN) begin
      if (slot_end) begin
        presc_d = '0;
        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    // The wrap always moves the staging contents seen before this edge.
    stg_val_d    = iLOAD ? iVALUE : stg_val_q;
    stg_dp_d     = iLOAD ? iDP : stg_dp_q;
    stg_lz_d     = iLOAD ? iLZ : stg_lz_q;
    disp_val_d   = (wrap && pend_q) ? stg_val_q : disp_val_q;
    disp_dp_d    = (wrap && pend_q) ? stg_dp_q : disp_dp_q;
    disp_lz_d    = (wrap && pend_q) ? stg_lz_q : disp_lz_q;
    pend_d       = iLOAD ? 1'b1 : (wrap ? 1'b0 : pend_q);
    frame_pend_d = wrap && pend_q;
    frame_d      = frame_pend_q;

    lit    = iEN && (presc_q >= PRE_DEAD);
    com_on = NDIG'(1) << idx_q;
    seg_d  = SEG_OFF;
    dp_d   = 1'b1;
    com_d  = COM_OFF;
    if (lit) begin
      seg_d = cur_blank ? SEG_OFF : hex_seg;
      dp_d  = ~cur_dp;
      com_d = COM_ACTIVE_LOW ? ~com_on : com_on;
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      presc_q      <= '0;
      idx_q        <= '0;
      stg_val_q    <= '0;
      stg_dp_q     <= '0;
      stg_lz_q     <= 1'b0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      disp_lz_q    <= 1'b0;
      pend_q       <= 1'b0;
      frame_pend_q <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      com_q        <= COM_OFF;
      frame_q      <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      stg_val_q    <= stg_val_d;
      stg_dp_q     <= stg_dp_d;
      stg_lz_q     <= stg_lz_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      disp_lz_q    <= disp_lz_d;
      pend_q       <= pend_d;
      frame_pend_q <= frame_pend_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      com_q        <= com_d;
      frame_q      <= frame_d;
    end
  end

  assign oSEG   = seg_q;
  assign oDP    = dp_q;
  assign oCOM   = com_q;
  assign oFRAME = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: cycle scoreboard on a 4-digit instance plus
// directed slot checks, and a 1-digit active-high-common instance.
module tb_seg_scan_driver;

  localparam int NDIG = 4;
  localparam int CDIV = 8;
  localparam int DEAD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, lz, load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [6:0]  seg;
  logic        odp, frame;
  logic [3:0]  com;

  logic        load2, lz2;
  logic [0:0]  dp2;
  logic [6:0]  seg2;
  logic        odp2, frame2;
  logic [0:0]  com2;

  int n_chk  = 0;
  int n_fail = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg_scan_driver #(.NDIG(NDIG), .CLK_DIV(CDIV), .DEAD_CYC(DEAD), .COM_ACTIVE_LOW(1'b1)) u_dut (
    .iCLK(clk), .iRST_N(rst_n), .iEN(en), .iVALUE(value), .iDP(dp), .iLZ(lz), .iLOAD(load),
    .oSEG(seg), .oDP(odp), .oCOM(com), .oFRAME(frame)
  );

  seg_scan_driver #(.NDIG(1), .CLK_DIV(CDIV), .DEAD_CYC(DEAD), .COM_ACTIVE_LOW(1'b0)) u_dut1 (
    .iCLK(clk), .iRST_N(rst_n), .iEN(1'b1), .iVALUE(value[3:0]), .iDP(dp2), .iLZ(lz2), .iLOAD(load2),
    .oSEG(seg2), .oDP(odp2), .oCOM(com2), .oFRAME(frame2)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model of the 4-digit instance; expectations queued per edge.
  int          m_tick, m_slot;
  logic [15:0] m_stg_v, m_disp_v;
  logic [3:0]  m_stg_dp, m_disp_dp;
  logic        m_stg_lz, m_disp_lz, m_pend, m_frame_next;
  logic [12:0] sb_q [$];

  always @(posedge clk) begin
    logic [6:0] es;
    logic       edp, ef, blank;
    logic [3:0] ec, dg;
    es = 7'h7F; edp = 1'b1; ec = 4'hF; ef = 1'b0;
    if (!rst_n) begin
      m_tick = 0; m_slot = 0; m_stg_v = '0; m_disp_v = '0; m_stg_dp = '0; m_disp_dp = '0;
      m_stg_lz = 1'b0; m_disp_lz = 1'b0; m_pend = 1'b0; m_frame_next = 1'b0;
    end else begin
      ef = m_frame_next;
      m_frame_next = 1'b0;
      if (en && m_tick >= DEAD) begin
        dg    = 4'((m_disp_v >> (4 * m_slot)) & 16'hF);
        blank = m_disp_lz && (m_slot > 0) && ((m_disp_v >> (4 * m_slot)) == 16'h0);
        es    = blank ? 7'h7F : seg_tab[dg];
        edp   = !m_disp_dp[m_slot];
        ec    = ~(4'b0001 << m_slot);
      end
      if (en) begin
        if (m_tick == CDIV - 1) begin
          m_tick = 0;
          if (m_slot == NDIG - 1) begin
            m_slot = 0;
            if (m_pend) begin
              m_disp_v = m_stg_v; m_disp_dp = m_stg_dp; m_disp_lz = m_stg_lz;
              m_pend = 1'b0; m_frame_next = 1'b1;
            end
          end else begin
            m_slot++;
          end
        end else begin
          m_tick++;
        end
      end
      if (load) begin
        m_stg_v = value; m_stg_dp = dp; m_stg_lz = lz; m_pend = 1'b1;
      end
    end
    sb_q.push_back({ef, edp, es, ec});
  end

  always @(negedge clk) begin
    logic [12:0] e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq("scan", {19'd0, frame, odp, seg, com}, {19'd0, e});
    end
  end

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d, input logic z);
    value = v; dp = d; lz = z; load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    int n;
    step(1);
    n = 1;
    while (frame !== 1'b1 && n < 100) begin
      step(1);
      n++;
    end
    check_eq(tag, {31'd0, frame}, 32'd1);
  endtask

  // Called in the oFRAME cycle; walks the whole frame that follows.
  task automatic check_frame(input string tag, input logic [27:0] segs, input logic [3:0] d);
    logic [3:0] ec;
    for (int j = 1; j < 32; j++) begin
      step(1);
      if (j % 8 < 2) begin
        check_eq({tag, "_dark"}, {28'd0, com}, 32'hF);
      end else if (j % 8 == 2 || j % 8 == 7) begin
        ec = ~(4'b0001 << (j / 8));
        check_eq({tag, "_com"}, {28'd0, com}, {28'd0, ec});
        check_eq({tag, "_seg"}, {25'd0, seg}, {25'd0, segs[(j / 8) * 7 +: 7]});
        check_eq({tag, "_dp"}, {31'd0, odp}, {31'd0, !d[j / 8]});
      end
    end
  endtask

  initial begin
    int nfr;
    rst_n = 1'b0; en = 1'b1; lz = 1'b0; load = 1'b0; value = '0; dp = '0;
    load2 = 1'b0; lz2 = 1'b0; dp2 = '0;
    step(3);
    check_eq("rst_com", {28'd0, com}, 32'hF);
    check_eq("rst_seg", {25'd0, seg}, 32'h7F);
    check_eq("rst_dp", {31'd0, odp}, 32'd1);
    check_eq("rst_frame", {31'd0, frame}, 32'd0);
    check_eq("rst_com1", {31'd0, com2}, 32'd0);

    rst_n = 1'b1; load2 = 1'b1; lz2 = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step(1);
      load2 = 1'b0;
      check_eq("w1_com", {31'd0, com2}, ((k - 1) % 8 >= 2) ? 32'd1 : 32'd0);
      if ((k - 1) % 8 >= 2) check_eq("w1_seg", {25'd0, seg2}, 32'h40);
      if (k <= 2) check_eq("rel_dark", {28'd0, com}, 32'hF);
      if (k == 3) begin
        check_eq("rel_com", {28'd0, com}, 32'hE);
        check_eq("rel_seg", {25'd0, seg}, 32'h40);
      end
    end

    pulse_load(16'h12AF, 4'h0, 1'b0);
    step(2);
    check_eq("pre_rst_com", {28'd0, com}, 32'h7);
    rst_n = 1'b0;
    step(1);
    check_eq("mid_rst_com", {28'd0, com}, 32'hF);
    check_eq("mid_rst_seg", {25'd0, seg}, 32'h7F);
    check_eq("mid_rst_dp", {31'd0, odp}, 32'd1);
    rst_n = 1'b1;
    nfr = 0;
    for (int k = 0; k < 40; k++) begin
      step(1);
      if (frame === 1'b1) nfr++;
    end
    check_eq("pend_dropped", nfr, 32'd0);

    pulse_load(16'h12AF, 4'h0, 1'b0);
    wait_frame("load_frame");
    check_frame("scan12af", {7'h79, 7'h24, 7'h08, 7'h0E}, 4'h0);

    pulse_load(16'h0050, 4'b1000, 1'b1);
    wait_frame("lz_frame");
    check_frame("lz", {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1000);

    step(10);
    pulse_load(16'h1111, 4'h0, 1'b0);
    step(7);
    pulse_load(16'h2222, 4'h0, 1'b0);
    wait_frame("tear_frame");
    check_frame("tear", {7'h24, 7'h24, 7'h24, 7'h24}, 4'h0);

    step(10);
    pulse_load(16'h4444, 4'h0, 1'b0);
    step(20);
    pulse_load(16'h3333, 4'h0, 1'b0);
    check_eq("wrap_frame", {31'd0, frame}, 32'd0);
    step(1);
    check_eq("wrap_old_frame", {31'd0, frame}, 32'd1);
    step(2);
    check_eq("wrap_old_seg", {25'd0, seg}, 32'h19);
    wait_frame("wrap_new_frame");
    step(2);
    check_eq("wrap_new_com", {28'd0, com}, 32'hE);
    check_eq("wrap_new_seg", {25'd0, seg}, 32'h30);

    step(18);
    en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      check_eq("dis_com", {28'd0, com}, 32'hF);
      check_eq("dis_seg", {25'd0, seg}, 32'h7F);
    end
    en = 1'b1;
    step(1);
    check_eq("resume_com", {28'd0, com}, 32'hB);
    check_eq("resume_seg", {25'd0, seg}, 32'h30);
    step(2);
    check_eq("resume_last", {28'd0, com}, 32'hB);
    step(1);
    check_eq("resume_dead", {28'd0, com}, 32'hF);
    step(2);
    check_eq("resume_next", {28'd0, com}, 32'h7);

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
